// File: rtl/ipv4_rx.sv
// ipv4_rx
//   IPv4 receive stage sitting between the Ethernet MAC rx payload stream and
//   udp_rx. It parses the fixed 20-byte IPv4 header and drops frames that are
//   not plain, unfragmented UDP addressed to LOCAL_IP. It also checks the header
//   checksum. The IP payload is then forwarded with zero latency, trimmed to
//   Total Length so that Ethernet padding never reaches the UDP stage.
//
// Ports
//   clk, nreset        clock, synchronous active-low reset
//   cancel_i           MAC aborts the current frame
//   valid_i/start_i    input beat valid / first beat of the IP header
//   data_i/len_i       beat data (bits [7:0] = earlier byte), valid byte count
//   valid_o/start_o    payload beat valid / first payload beat
//   data_o/len_o       payload data and valid byte count (1 or 2)
//   cs_err_o           header checksum failed, held across the payload
//   cancel_o           downstream must discard the payload in flight
module ipv4_rx #(
  parameter int          DATA_W   = 16,
  parameter int          LEN_W    = 2,
  parameter logic [31:0] LOCAL_IP = 32'hC0A80102
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              cs_err_o,
  output logic              cancel_o
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    DATA = 4'b0100,
    DROP = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [15:0] acc_q, acc_d;
  logic        drop_q, drop_d;
  logic        cs_err_q, cs_err_d;
  logic        first_q, first_d;

  logic [7:0]  byte_lo;
  logic [7:0]  byte_hi;
  logic [15:0] word_be;
  logic [15:0] len_ext;
  logic        start_beat;
  logic [15:0] hdr_idx;
  logic [15:0] acc_base;
  logic [16:0] acc_sum;
  logic [15:0] acc_fold;
  logic        hdr_fail;
  logic [15:0] pay_len;
  logic [15:0] cnt_add;
  logic [15:0] remain;
  logic        in_data;

  assign byte_lo = data_i[7:0];
  assign byte_hi = data_i[15:8];
  // Header fields are big-endian: the earlier byte is the most significant.
  assign word_be = {byte_lo, byte_hi};
  assign len_ext = {{(16-LEN_W){1'b0}}, len_i};

  // A start beat is always header bytes 0-1, whatever state we are in, unless
  // the MAC cancels on the same cycle.
  assign start_beat = valid_i & start_i & ~cancel_i;
  assign hdr_idx    = start_beat ? 16'd0 : cnt_q;

  // Ones-complement sum with end-around carry folded every beat, so the
  // stored value never needs more than 16 bits.
  assign acc_base = start_beat ? 16'd0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, word_be};
  assign acc_fold = acc_sum[15:0] + {15'd0, acc_sum[16]};

  // A Total Length below the header size is already a filter failure; treat
  // its payload as empty so the frame cannot wedge the FSM in DROP.
  assign pay_len = (tot_len_q < 16'd20) ? 16'd0 : tot_len_q - 16'd20;
  assign cnt_add = cnt_q + len_ext;
  assign remain  = pay_len - cnt_q;
  assign in_data = (state_q == DATA);

  // Field filters, evaluated on whichever beat carries the field.
  always_comb begin
    hdr_fail = 1'b0;
    case (hdr_idx)
      16'd0:  hdr_fail = (byte_lo != 8'h45);
      16'd2:  hdr_fail = (word_be < 16'd20);
      16'd6:  hdr_fail = word_be[13] | (word_be[12:0] != 13'd0);
      16'd8:  hdr_fail = (byte_hi != 8'd17);
      16'd16: hdr_fail = (word_be != LOCAL_IP[31:16]);
      16'd18: hdr_fail = (word_be != LOCAL_IP[15:0]);
      default: hdr_fail = 1'b0;
    endcase
  end

  // Next-state logic. Cancel beats everything; a start beat restarts the
  // header parse from any state; otherwise the FSM only moves on valid beats.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tot_len_d = tot_len_q;
    acc_d     = acc_q;
    drop_d    = drop_q;
    cs_err_d  = cs_err_q;
    first_d   = first_q;

    if (state_q == IDLE) begin
      drop_d   = 1'b0;
      cs_err_d = 1'b0;
      first_d  = 1'b0;
    end

    if (cancel_i) begin
      state_d = IDLE;
    end else if (start_beat) begin
      state_d  = HEAD;
      cnt_d    = len_ext;
      acc_d    = acc_fold;
      drop_d   = hdr_fail;
      cs_err_d = 1'b0;
      first_d  = 1'b0;
    end else if (valid_i) begin
      case (state_q)
        HEAD: begin
          cnt_d  = cnt_q + len_ext;
          acc_d  = acc_fold;
          drop_d = drop_q | hdr_fail;
          if (hdr_idx == 16'd2) begin
            tot_len_d = word_be;
          end
          // Bytes 18-19 close the header: latch the checksum verdict and
          // restart the counter for payload bytes.
          if (cnt_q == 16'd18) begin
            cnt_d    = 16'd0;
            cs_err_d = (acc_fold != 16'hFFFF);
            if (pay_len == 16'd0) begin
              state_d = IDLE;
            end else if (drop_q | hdr_fail) begin
              state_d = DROP;
            end else begin
              state_d = DATA;
              first_d = 1'b1;
            end
          end
        end
        DATA, DROP: begin
          cnt_d   = cnt_add;
          first_d = 1'b0;
          if (cnt_add >= pay_len) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State register; every register is cleared so outputs are quiet after reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      tot_len_q <= 16'd0;
      acc_q     <= 16'd0;
      drop_q    <= 1'b0;
      cs_err_q  <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tot_len_q <= tot_len_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
      cs_err_q  <= cs_err_d;
      first_q   <= first_d;
    end
  end

  // Outputs are combinational from the current beat. A start beat seen in
  // DATA is header data of the next frame and a cancelled beat is discarded,
  // so neither is forwarded. Everything is held low while reset is asserted,
  // and data/len read zero whenever no payload beat is being presented.
  always_comb begin
    valid_o  = nreset & valid_i & in_data & ~drop_q & ~start_i & ~cancel_i;
    start_o  = valid_o & first_q;
    data_o   = valid_o ? data_i : '0;
    len_o    = '0;
    if (valid_o) begin
      len_o = (remain < len_ext) ? remain[LEN_W-1:0] : len_i;
    end
    cs_err_o = nreset & cs_err_q & in_data;
    cancel_o = nreset & ((cancel_i & in_data) | (start_beat & (state_q != IDLE)));
  end

endmodule
